// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: bundles the IRQ pins, CPU/CSR handshake and mask/status
// signals of the interrupt controller.
//   master: CPU/CSR/board side (drives IRQ, CSR_ME, INSTR_BOUNDARY, MRET, mask write)
//   slave : intr_ctrl (drives INT_TAKEN, INT_ID, PENDING, MASK, IN_SERVICE)
interface intr_ctrl_if #(
  parameter int NUM_SRC = 4
);
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] IRQ;
  logic               CSR_ME;
  logic               INSTR_BOUNDARY;
  logic               MRET;
  logic               MASK_WE;
  logic [NUM_SRC-1:0] MASK_WD;
  logic               INT_TAKEN;
  logic [IDW-1:0]     INT_ID;
  logic [NUM_SRC-1:0] PENDING;
  logic [NUM_SRC-1:0] MASK;
  logic               IN_SERVICE;

  modport master (
    output IRQ, CSR_ME, INSTR_BOUNDARY, MRET, MASK_WE, MASK_WD,
    input  INT_TAKEN, INT_ID, PENDING, MASK, IN_SERVICE
  );

  modport slave (
    input  IRQ, CSR_ME, INSTR_BOUNDARY, MRET, MASK_WE, MASK_WD,
    output INT_TAKEN, INT_ID, PENDING, MASK, IN_SERVICE
  );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: multi-source interrupt controller sequencing trap entry.
// Synchronizes IRQ lines, latches pending (edge or level), applies mask and
// fixed lowest-index-first priority, raises INT_TAKEN at an instruction
// boundary while CSR_ME is set, and tracks in-service state until MRET.
// Ports:
//   CLK   - system clock, rising edge
//   RESET - synchronous active-high reset
//   bus   - intr_ctrl_if.slave (IRQ, CSR_ME, INSTR_BOUNDARY, MRET, MASK_WE,
//           MASK_WD in; INT_TAKEN, INT_ID, PENDING, MASK, IN_SERVICE out)
module intr_ctrl #(
  parameter int NUM_SRC = 4,
  parameter bit EDGE    = 1'b1
) (
  input logic       CLK,
  input logic       RESET,
  intr_ctrl_if.slave bus
);
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVICE,
    ST_RETURN
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] s1_q, s1_d;
  logic [NUM_SRC-1:0] s2_q, s2_d;
  logic [NUM_SRC-1:0] s3_q, s3_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [IDW-1:0]     int_id_q, int_id_d;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [IDW-1:0]     prio_id;
  logic               any_elig;
  logic               take;
  logic               in_service;

  // Lowest eligible index wins.
  always_comb begin
    elig     = pending_q & mask_q;
    prio_id  = '0;
    any_elig = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && !any_elig) begin
        prio_id  = IDW'(i);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    int_id_d   = int_id_q;
    take       = 1'b0;
    in_service = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig && bus.CSR_ME && bus.INSTR_BOUNDARY) begin
          take     = 1'b1;
          int_id_d = prio_id;
          state_d  = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        in_service = 1'b1;
        if (bus.MRET) state_d = ST_RETURN;
      end
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Set wins over clear when both hit the same bit: rise is OR-ed in last.
  always_comb begin
    s1_d = bus.IRQ;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
    clr  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      clr[i] = take && (prio_id == IDW'(i));
    end
    if (EDGE) pending_d = (pending_q & ~clr) | rise;
    else      pending_d = s2_q;
    mask_d = bus.MASK_WE ? bus.MASK_WD : mask_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      int_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      int_id_q  <= int_id_d;
    end
  end

  assign bus.INT_TAKEN  = take;
  assign bus.INT_ID     = take ? prio_id : int_id_q;
  assign bus.PENDING    = pending_q;
  assign bus.MASK       = mask_q;
  assign bus.IN_SERVICE = in_service;
endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  intr_ctrl_if #(.NUM_SRC(4)) bus_e ();
  intr_ctrl_if #(.NUM_SRC(4)) bus_l ();

  intr_ctrl #(.NUM_SRC(4), .EDGE(1'b1)) dut_e (.CLK(CLK), .RESET(RESET), .bus(bus_e.slave));
  intr_ctrl #(.NUM_SRC(4), .EDGE(1'b0)) dut_l (.CLK(CLK), .RESET(RESET), .bus(bus_l.slave));

  // Reference model for the edge-mode instance: IRQ sample history,
  // pending/mask vectors, and two booleans for "handler running" and
  // "post-MRET guard cycle".
  logic [3:0] m_hist0, m_hist1, m_hist2;
  logic [3:0] m_pend, m_mask;
  bit         m_busy, m_guard;
  int         m_id;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit exp_take();
    return !m_busy && !m_guard && ((m_pend & m_mask) != 4'b0) &&
           bus_e.CSR_ME && bus_e.INSTR_BOUNDARY;
  endfunction

  function automatic int exp_id();
    return exp_take() ? lowest(m_pend & m_mask) : m_id;
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      m_hist0 <= 4'b0; m_hist1 <= 4'b0; m_hist2 <= 4'b0;
      m_pend  <= 4'b0; m_mask  <= 4'hF;
      m_busy  <= 1'b0; m_guard <= 1'b0; m_id <= 0;
    end else begin
      m_pend <= (m_pend & ~(exp_take() ? (4'b1 << lowest(m_pend & m_mask)) : 4'b0))
                | (m_hist1 & ~m_hist2);
      if (exp_take()) begin
        m_busy <= 1'b1;
        m_id   <= lowest(m_pend & m_mask);
      end else if (m_busy && bus_e.MRET) begin
        m_busy  <= 1'b0;
        m_guard <= 1'b1;
      end else begin
        m_guard <= 1'b0;
      end
      if (bus_e.MASK_WE) m_mask <= bus_e.MASK_WD;
      m_hist0 <= bus_e.IRQ;
      m_hist1 <= m_hist0;
      m_hist2 <= m_hist1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    bus_e.IRQ = '0; bus_e.CSR_ME = 1'b0; bus_e.INSTR_BOUNDARY = 1'b0;
    bus_e.MRET = 1'b0; bus_e.MASK_WE = 1'b0; bus_e.MASK_WD = '0;
    bus_l.IRQ = '0; bus_l.CSR_ME = 1'b0; bus_l.INSTR_BOUNDARY = 1'b0;
    bus_l.MRET = 1'b0; bus_l.MASK_WE = 1'b0; bus_l.MASK_WD = '0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0) begin n_fail++; $display("FAIL reset_pend: got %b want 0000", bus_e.PENDING); end
    n_checks++; if (bus_e.MASK !== 4'hF) begin n_fail++; $display("FAIL reset_mask: got %b want 1111", bus_e.MASK); end
    n_checks++; if (bus_e.IN_SERVICE !== 1'b0) begin n_fail++; $display("FAIL reset_insvc: got %b want 0", bus_e.IN_SERVICE); end
    n_checks++; if (bus_e.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", bus_e.INT_TAKEN); end
    n_checks++; if (bus_e.INT_ID !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus_e.INT_ID); end
    n_checks++; if (bus_l.MASK !== 4'hF) begin n_fail++; $display("FAIL reset_mask_lvl: got %b want 1111", bus_l.MASK); end
  endtask

  task automatic test_single();
    do_reset();
    bus_e.CSR_ME = 1'b1; bus_e.INSTR_BOUNDARY = 1'b1; bus_e.IRQ = 4'b0100;
    tick(); tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0 || bus_e.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL single_early: pend %b taken %b want 0000/0", bus_e.PENDING, bus_e.INT_TAKEN); end
    tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0100) begin n_fail++; $display("FAIL single_pend: got %b want 0100", bus_e.PENDING); end
    n_checks++; if (bus_e.INT_TAKEN !== 1'b1) begin n_fail++; $display("FAIL single_taken: got %b want 1", bus_e.INT_TAKEN); end
    n_checks++; if (bus_e.INT_ID !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", bus_e.INT_ID); end
    tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0) begin n_fail++; $display("FAIL single_clr: got %b want 0000", bus_e.PENDING); end
    n_checks++; if (bus_e.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL single_width: got %b want 0", bus_e.INT_TAKEN); end
    n_checks++; if (bus_e.IN_SERVICE !== 1'b1 || bus_e.INT_ID !== 2'd2) begin n_fail++; $display("FAIL single_svc: insvc %b id %0d want 1/2", bus_e.IN_SERVICE, bus_e.INT_ID); end
    bus_e.MRET = 1'b1;
    tick();
    bus_e.MRET = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus_e.IN_SERVICE !== 1'b0) begin n_fail++; $display("FAIL single_mret: insvc %b want 0", bus_e.IN_SERVICE); end
  endtask

  task automatic test_priority();
    do_reset();
    bus_e.CSR_ME = 1'b1; bus_e.INSTR_BOUNDARY = 1'b1; bus_e.IRQ = 4'b1010;
    tick(); tick(); tick();
    @(negedge CLK);
    n_checks++; if (bus_e.INT_TAKEN !== 1'b1 || bus_e.INT_ID !== 2'd1) begin n_fail++; $display("FAIL prio_first: taken %b id %0d want 1/1", bus_e.INT_TAKEN, bus_e.INT_ID); end
    tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b1000) begin n_fail++; $display("FAIL prio_remain: got %b want 1000", bus_e.PENDING); end
    bus_e.MRET = 1'b1;
    tick();
    bus_e.MRET = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus_e.INT_TAKEN !== 1'b0 || bus_e.IN_SERVICE !== 1'b0) begin n_fail++; $display("FAIL prio_guard: taken %b insvc %b want 0/0", bus_e.INT_TAKEN, bus_e.IN_SERVICE); end
    tick();
    @(negedge CLK);
    n_checks++; if (bus_e.INT_TAKEN !== 1'b1 || bus_e.INT_ID !== 2'd3) begin n_fail++; $display("FAIL prio_second: taken %b id %0d want 1/3", bus_e.INT_TAKEN, bus_e.INT_ID); end
  endtask

  task automatic test_gating();
    do_reset();
    bus_e.CSR_ME = 1'b0; bus_e.INSTR_BOUNDARY = 1'b1; bus_e.IRQ = 4'b0001;
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_checks++; if (bus_e.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL gate_me cycle %0d: got %b want 0", i, bus_e.INT_TAKEN); end
      tick();
    end
    bus_e.CSR_ME = 1'b1; bus_e.INSTR_BOUNDARY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_checks++; if (bus_e.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL gate_bnd cycle %0d: got %b want 0", i, bus_e.INT_TAKEN); end
      tick();
    end
    bus_e.INSTR_BOUNDARY = 1'b1;
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0001) begin n_fail++; $display("FAIL gate_kept: got %b want 0001", bus_e.PENDING); end
    n_checks++; if (bus_e.INT_TAKEN !== 1'b1 || bus_e.INT_ID !== 2'd0) begin n_fail++; $display("FAIL gate_take: taken %b id %0d want 1/0", bus_e.INT_TAKEN, bus_e.INT_ID); end
  endtask

  task automatic test_mask();
    do_reset();
    bus_e.CSR_ME = 1'b1; bus_e.INSTR_BOUNDARY = 1'b1;
    bus_e.MASK_WE = 1'b1; bus_e.MASK_WD = 4'b1110;
    tick();
    bus_e.MASK_WE = 1'b0;
    bus_e.IRQ = 4'b0001;
    @(negedge CLK);
    n_checks++; if (bus_e.MASK !== 4'b1110) begin n_fail++; $display("FAIL mask_wr: got %b want 1110", bus_e.MASK); end
    tick();
    bus_e.IRQ = 4'b0000;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_checks++; if (bus_e.PENDING !== 4'b0001 || bus_e.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL mask_hold cycle %0d: pend %b taken %b want 0001/0", i, bus_e.PENDING, bus_e.INT_TAKEN); end
      tick();
    end
    bus_e.MASK_WE = 1'b1; bus_e.MASK_WD = 4'b1111;
    tick();
    bus_e.MASK_WE = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus_e.INT_TAKEN !== 1'b1 || bus_e.INT_ID !== 2'd0) begin n_fail++; $display("FAIL mask_take: taken %b id %0d want 1/0", bus_e.INT_TAKEN, bus_e.INT_ID); end
  endtask

  task automatic test_during_service();
    do_reset();
    bus_e.CSR_ME = 1'b1; bus_e.INSTR_BOUNDARY = 1'b1; bus_e.IRQ = 4'b0100;
    tick(); tick(); tick();
    tick();
    bus_e.IRQ = 4'b0000;
    tick();
    bus_e.IRQ = 4'b0100;
    tick(); tick(); tick(); tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0100 || bus_e.IN_SERVICE !== 1'b1 || bus_e.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL svc_newreq: pend %b insvc %b taken %b want 0100/1/0", bus_e.PENDING, bus_e.IN_SERVICE, bus_e.INT_TAKEN); end
    // Time a fresh rise so its pending set lands on the take edge.
    bus_e.IRQ = 4'b0000;
    tick();
    bus_e.IRQ = 4'b0100; bus_e.MRET = 1'b1;
    tick();
    bus_e.MRET = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus_e.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL svc_guard: got %b want 0", bus_e.INT_TAKEN); end
    tick();
    @(negedge CLK);
    n_checks++; if (bus_e.INT_TAKEN !== 1'b1 || bus_e.INT_ID !== 2'd2) begin n_fail++; $display("FAIL svc_retake: taken %b id %0d want 1/2", bus_e.INT_TAKEN, bus_e.INT_ID); end
    tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0100 || bus_e.IN_SERVICE !== 1'b1) begin n_fail++; $display("FAIL svc_collision: pend %b insvc %b want 0100/1", bus_e.PENDING, bus_e.IN_SERVICE); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_e.CSR_ME = 1'b1; bus_e.INSTR_BOUNDARY = 1'b1; bus_e.IRQ = 4'b0010;
    tick(); tick(); tick();
    tick();
    bus_e.IRQ = 4'b0100;
    tick();
    bus_e.IRQ = 4'b0110;
    tick(); tick(); tick(); tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0110 || bus_e.IN_SERVICE !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: pend %b insvc %b want 0110/1", bus_e.PENDING, bus_e.IN_SERVICE); end
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    n_checks++; if (bus_e.PENDING !== 4'b0 || bus_e.MASK !== 4'hF || bus_e.IN_SERVICE !== 1'b0 ||
                    bus_e.INT_TAKEN !== 1'b0 || bus_e.INT_ID !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_post: pend %b mask %b insvc %b taken %b id %0d want 0000/1111/0/0/0",
                         bus_e.PENDING, bus_e.MASK, bus_e.IN_SERVICE, bus_e.INT_TAKEN, bus_e.INT_ID);
    end
    RESET = 1'b0;
  endtask

  task automatic test_level();
    do_reset();
    bus_l.CSR_ME = 1'b1; bus_l.INSTR_BOUNDARY = 1'b1; bus_l.IRQ = 4'b0010;
    tick(); tick(); tick();
    for (int r = 0; r < 3; r++) begin
      @(negedge CLK);
      n_checks++; if (bus_l.INT_TAKEN !== 1'b1 || bus_l.INT_ID !== 2'd1) begin n_fail++; $display("FAIL lvl_take round %0d: taken %b id %0d want 1/1", r, bus_l.INT_TAKEN, bus_l.INT_ID); end
      tick();
      @(negedge CLK);
      n_checks++; if (bus_l.PENDING !== 4'b0010 || bus_l.IN_SERVICE !== 1'b1) begin n_fail++; $display("FAIL lvl_svc round %0d: pend %b insvc %b want 0010/1", r, bus_l.PENDING, bus_l.IN_SERVICE); end
      bus_l.MRET = 1'b1;
      tick();
      bus_l.MRET = 1'b0;
      @(negedge CLK);
      n_checks++; if (bus_l.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL lvl_guard round %0d: got %b want 0", r, bus_l.INT_TAKEN); end
      tick();
    end
    // Source quiesced during the fourth service.
    tick();
    bus_l.IRQ = 4'b0000;
    tick(); tick(); tick();
    @(negedge CLK);
    n_checks++; if (bus_l.PENDING !== 4'b0) begin n_fail++; $display("FAIL lvl_fall: pend %b want 0000", bus_l.PENDING); end
    bus_l.MRET = 1'b1;
    tick();
    bus_l.MRET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge CLK);
      n_checks++; if (bus_l.INT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL lvl_quiet cycle %0d: got %b want 0", i, bus_l.INT_TAKEN); end
    end
  endtask

  task automatic test_random();
    do_reset();
    bus_e.IRQ = 4'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) bus_e.IRQ[b] = ~bus_e.IRQ[b];
      bus_e.CSR_ME         = ($urandom_range(7) != 0);
      bus_e.INSTR_BOUNDARY = $urandom_range(1) == 1;
      bus_e.MRET           = ($urandom_range(3) == 0);
      bus_e.MASK_WE        = ($urandom_range(15) == 0);
      bus_e.MASK_WD        = 4'($urandom_range(15));
      RESET                = ($urandom_range(199) == 0);
      @(negedge CLK);
      n_checks++; if (bus_e.INT_TAKEN !== exp_take()) begin n_fail++; $display("FAIL rnd_taken cycle %0d: got %b want %b", c, bus_e.INT_TAKEN, exp_take()); end
      n_checks++; if (bus_e.INT_ID !== 2'(exp_id())) begin n_fail++; $display("FAIL rnd_id cycle %0d: got %0d want %0d", c, bus_e.INT_ID, exp_id()); end
      n_checks++; if (bus_e.PENDING !== m_pend) begin n_fail++; $display("FAIL rnd_pend cycle %0d: got %b want %b", c, bus_e.PENDING, m_pend); end
      n_checks++; if (bus_e.MASK !== m_mask) begin n_fail++; $display("FAIL rnd_mask cycle %0d: got %b want %b", c, bus_e.MASK, m_mask); end
      n_checks++; if (bus_e.IN_SERVICE !== m_busy) begin n_fail++; $display("FAIL rnd_insvc cycle %0d: got %b want %b", c, bus_e.IN_SERVICE, m_busy); end
      tick();
    end
    RESET = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_gating();
    test_mask();
    test_during_service();
    test_reset_mid();
    test_level();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
